phys_freelist_ckpt: RTL and testbench
=====================================

Name: phys_freelist_ckpt

Overview:
- Parametrised physical-register free list for the rename stage. Supplies up to ALLOC_WIDTH free physical tags per cycle and accepts up to FREE_WIDTH retired tags per cycle from commit.
- Exports a head-pointer snapshot for branch checkpoints. On misprediction, restores the head from a snapshot in one cycle.
- Successor to the single-issue free-list assumption: multi-lane allocate and free, parametrised depth, wrap-tagged pointers.

Parameters:
- NUM_PHYS_REGS, 128, physical register file size.
- NUM_ARCH_REGS, 32, architectural registers; tags 0..NUM_ARCH_REGS-1 are mapped at reset.
- ALLOC_WIDTH, 2, allocation lanes per cycle.
- FREE_WIDTH, 2, free (commit) lanes per cycle.
- Derived: DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGS (96); PRB = $clog2(NUM_PHYS_REGS); PTR_BITS = $clog2(DEPTH)+1.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- alloc_count, input, $clog2(ALLOC_WIDTH+1), number of tags requested this cycle.
- alloc_preg, output, ALLOC_WIDTH*PRB, tags at head..head+ALLOC_WIDTH-1; lane 0 is oldest.
- alloc_ok, output, 1, free_count >= alloc_count and not recover_valid.
- free_valid, input, FREE_WIDTH, per-lane free strobe.
- free_preg, input, FREE_WIDTH*PRB, tags being released (prd_old at commit).
- ckpt_head_ptr, output, PTR_BITS, current head pointer for a checkpoint snapshot.
- recover_valid, input, 1, restore head.
- recover_head_ptr, input, PTR_BITS, snapshot to restore.
- free_count, output, $clog2(DEPTH+1), entries available.
- overflow_err, output, 1, sticky; a push was attempted while full.

Behaviour:
- Storage: DEPTH-entry circular array of PRB-bit tags. head and tail are PTR_BITS wrap-tagged pointers in range 0..2*DEPTH-1. index = ptr mod DEPTH. Pointer increment wraps 2*DEPTH-1 -> 0.
- free_count = (tail - head) mod 2*DEPTH, computed combinationally from registers.
- Reset (async): entry i = NUM_ARCH_REGS+i, head=0, tail=DEPTH, free_count=DEPTH, overflow_err=0, alloc_ok=1 when alloc_count<=ALLOC_WIDTH.
- alloc_preg is combinational from the array. Lanes at or beyond free_count show stale data and must be ignored.
- Allocation is all-or-nothing:
  - When alloc_ok and alloc_count>0: head += alloc_count at the clock edge.
  - When !alloc_ok: no change. Rename stalls.
- Free:
  - Valid lanes are pushed in lane order (lane 0 first) at tail. Lane positions are compacted; invalid lanes are skipped. tail += popcount of accepted lanes.
  - free_preg==0 is ignored (x0 mapping never recycled).
  - A lane that would exceed DEPTH entries, counting lower lanes this cycle, is dropped and sets overflow_err. overflow_err is cleared only by reset.
- Same cycle alloc and free: occupancy for alloc_ok is the pre-edge free_count. Freed tags cannot be allocated in the same cycle. Both pointer updates apply.
- Recovery: when recover_valid, head <= recover_head_ptr next edge. Allocation is suppressed (alloc_ok=0). Frees in the same cycle still apply to tail, because commits are older than the branch.
- recover_head_ptr must lie within the [old head, tail] window. A value outside it is undefined use.
- Latency: a tag freed at edge N is visible on alloc_preg after edge N. Recovery takes effect for allocation at cycle N+1.
- Reset asserted mid-operation returns everything to reset state immediately, including any pending recovery.

Optional Feature:
- Macro FREELIST_DUP_CHECK_EN.
- Defined: keeps an NUM_PHYS_REGS-bit in_list vector.
  - Set on push, cleared on allocate.
  - On recovery, the vector is rebuilt from the array window [recover_head_ptr, tail) over DEPTH cycles. Allocation stays stalled via alloc_ok=0 until the rebuild completes.
  - A push of a tag already present is dropped and pulses output dup_err for 1 cycle.
- Not defined: no vector, no dup_err port, no rebuild stall. Recovery costs 1 cycle.

Test Plan:
- Reset, alloc_count=2 for 48 cycles -> tags 32,33…127 in order, then free_count=0 and alloc_ok=0.
- From empty, free lanes {1,0} with tag 40, then {1,1} with 41,42, then alloc_count=2 -> alloc_preg lanes = 40,41. free_count reaches 3, then drops to 1.
- Snapshot ckpt_head_ptr=4 after two 2-wide allocs, alloc 3 more times, assert recover_valid with 4 -> next alloc returns tags 36,37. free_count=92.
- Full list (reset state), free_valid=1 with tag 50 -> push dropped, overflow_err=1 and stays 1 until reset. free_count remains 96.
- Recover together with a 2-lane free of 70,71 -> head restored, tail += 2, alloc_ok=0 that cycle.
- Wrap test: 200 cycles of alloc 2/free 2 of the returned tags -> head/tail wrap past 191->0, free_count constant at 96, no overflow_err.

Source files
------------

// File: rtl/phys_freelist_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : phys_freelist_ckpt
// Purpose  : Multi-lane physical-register free list with head checkpoint and
//            one-cycle restore. Define FREELIST_DUP_CHECK_EN for dup detection.
// Revision : 1.0
// ============================================================================
module phys_freelist_ckpt #(
   parameter int NUM_PHYS_REGS = 128,
   parameter int NUM_ARCH_REGS = 32,
   parameter int ALLOC_WIDTH   = 2,
   parameter int FREE_WIDTH    = 2
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic [$clog2(ALLOC_WIDTH+1)-1:0]                     alloc_count,
   output logic [ALLOC_WIDTH*$clog2(NUM_PHYS_REGS)-1:0]         alloc_preg,
   output logic                                                 alloc_ok,
   input  logic [FREE_WIDTH-1:0]                                free_valid,
   input  logic [FREE_WIDTH*$clog2(NUM_PHYS_REGS)-1:0]          free_preg,
   output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0]         ckpt_head_ptr,
   input  logic                                                 recover_valid,
   input  logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0]         recover_head_ptr,
   output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS+1)-1:0]     free_count,
`ifdef FREELIST_DUP_CHECK_EN
   output logic                                                 dup_err,
`endif
   output logic                                                 overflow_err
);

   localparam int DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int PRB      = $clog2(NUM_PHYS_REGS);
   localparam int PTR_BITS = $clog2(DEPTH) + 1;
   localparam int IDX_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = $clog2(DEPTH + 1);
   localparam int AC_BITS  = $clog2(ALLOC_WIDTH + 1);
   localparam logic [PTR_BITS:0]   PTR_RANGE = (PTR_BITS+1)'(2 * DEPTH);
   localparam logic [PTR_BITS-1:0] DEPTH_PTR = PTR_BITS'(DEPTH);
   localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

   // Pointers live in 0..2*DEPTH-1; the extra lap distinguishes full from empty.
   function automatic logic [PTR_BITS-1:0] ptr_add(input logic [PTR_BITS-1:0] p,
                                                   input logic [PTR_BITS-1:0] k);
      logic [PTR_BITS:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= PTR_RANGE) s = s - PTR_RANGE;
      return s[PTR_BITS-1:0];
   endfunction

   function automatic logic [IDX_BITS-1:0] ptr_idx(input logic [PTR_BITS-1:0] p);
      logic [PTR_BITS-1:0] r;
      r = (p >= DEPTH_PTR) ? (p - DEPTH_PTR) : p;
      return r[IDX_BITS-1:0];
   endfunction

   function automatic logic [PTR_BITS:0] ptr_dist(input logic [PTR_BITS-1:0] from_p,
                                                  input logic [PTR_BITS-1:0] to_p);
      logic [PTR_BITS:0] d;
      d = {1'b0, to_p} - {1'b0, from_p};
      if (to_p < from_p) d = d + PTR_RANGE;
      return d;
   endfunction

   logic [PRB-1:0]      mem_q [DEPTH];
   logic [PRB-1:0]      mem_d [DEPTH];
   logic [PTR_BITS-1:0] head_q, head_d;
   logic [PTR_BITS-1:0] tail_q, tail_d;
   logic                overflow_err_q, overflow_err_d;

   logic [PTR_BITS:0]   occ_w;
   logic                alloc_fire_w;
   logic [CNT_BITS-1:0] push_occ_w;
   logic [PRB-1:0]      push_tag_w;
   logic                rebuild_busy_w;

`ifdef FREELIST_DUP_CHECK_EN
   logic [NUM_PHYS_REGS-1:0] in_list_q, in_list_d;
   logic                     rebuild_q, rebuild_d;
   logic [PTR_BITS-1:0]      rb_ptr_q, rb_ptr_d;
   logic [IDX_BITS-1:0]      rb_cnt_q, rb_cnt_d;
   logic                     dup_err_q, dup_err_d;

   assign rebuild_busy_w = rebuild_q;
   assign dup_err        = dup_err_q;
`else
   assign rebuild_busy_w = 1'b0;
`endif

   always_comb begin
      occ_w      = ptr_dist(head_q, tail_q);
      free_count = occ_w[CNT_BITS-1:0];
   end

   assign alloc_ok = (CNT_BITS'(alloc_count) <= free_count)
                   && (alloc_count <= AC_BITS'(ALLOC_WIDTH))
                   && !recover_valid && !rebuild_busy_w;
   assign alloc_fire_w  = alloc_ok && (alloc_count != '0);
   assign ckpt_head_ptr = head_q;
   assign overflow_err  = overflow_err_q;

   for (genvar g = 0; g < ALLOC_WIDTH; g++) begin : g_alloc_lane
      assign alloc_preg[g*PRB +: PRB] = mem_q[ptr_idx(ptr_add(head_q, PTR_BITS'(g)))];
   end

   always_comb begin
      mem_d          = mem_q;
      tail_d         = tail_q;
      head_d         = head_q;
      overflow_err_d = overflow_err_q;
      push_tag_w     = '0;
      // Entries handed out this edge vacate their slots, so they count as room.
      push_occ_w     = alloc_fire_w ? (free_count - CNT_BITS'(alloc_count)) : free_count;

`ifdef FREELIST_DUP_CHECK_EN
      in_list_d = in_list_q;
      rebuild_d = rebuild_q;
      rb_ptr_d  = rb_ptr_q;
      rb_cnt_d  = rb_cnt_q;
      dup_err_d = 1'b0;
      if (rebuild_q && (ptr_dist(head_q, rb_ptr_q) < (PTR_BITS+1)'(free_count)))
         in_list_d[mem_q[ptr_idx(rb_ptr_q)]] = 1'b1;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         if (alloc_fire_w && (AC_BITS'(i) < alloc_count))
            in_list_d[alloc_preg[i*PRB +: PRB]] = 1'b0;
      end
`endif

      if (recover_valid)
         head_d = recover_head_ptr;
      else if (alloc_fire_w)
         head_d = ptr_add(head_q, PTR_BITS'(alloc_count));

      // Lanes compact onto the tail in lane order; tag 0 is never recycled.
      for (int i = 0; i < FREE_WIDTH; i++) begin
         push_tag_w = free_preg[i*PRB +: PRB];
         if (free_valid[i] && (push_tag_w != '0)) begin
            if (push_occ_w == DEPTH_CNT) begin
               overflow_err_d = 1'b1;
`ifdef FREELIST_DUP_CHECK_EN
            end else if (in_list_d[push_tag_w]) begin
               dup_err_d = 1'b1;
`endif
            end else begin
               mem_d[ptr_idx(tail_d)] = push_tag_w;
               tail_d                 = ptr_add(tail_d, PTR_BITS'(1));
               push_occ_w             = push_occ_w + 1'b1;
`ifdef FREELIST_DUP_CHECK_EN
               in_list_d[push_tag_w]  = 1'b1;
`endif
            end
         end
      end

`ifdef FREELIST_DUP_CHECK_EN
      // The walk covers [restored head, tail); tail only grows meanwhile.
      if (recover_valid) begin
         in_list_d = '0;
         rebuild_d = 1'b1;
         rb_ptr_d  = recover_head_ptr;
         rb_cnt_d  = '0;
      end else if (rebuild_q) begin
         rb_ptr_d = ptr_add(rb_ptr_q, PTR_BITS'(1));
         rb_cnt_d = rb_cnt_q + 1'b1;
         if (rb_cnt_q == IDX_BITS'(DEPTH - 1)) rebuild_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= PRB'(NUM_ARCH_REGS + i);
         head_q         <= '0;
         tail_q         <= DEPTH_PTR;
         overflow_err_q <= 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
         for (int i = 0; i < NUM_PHYS_REGS; i++) in_list_q[i] <= (i >= NUM_ARCH_REGS);
         rebuild_q <= 1'b0;
         rb_ptr_q  <= '0;
         rb_cnt_q  <= '0;
         dup_err_q <= 1'b0;
`endif
      end else begin
         mem_q          <= mem_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         overflow_err_q <= overflow_err_d;
`ifdef FREELIST_DUP_CHECK_EN
         in_list_q <= in_list_d;
         rebuild_q <= rebuild_d;
         rb_ptr_q  <= rb_ptr_d;
         rb_cnt_q  <= rb_cnt_d;
         dup_err_q <= dup_err_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_phys_freelist_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : tb_phys_freelist_ckpt
// Purpose  : Directed self-checking bench for phys_freelist_ckpt (default build).
// Revision : 1.0
// ============================================================================
module tb_phys_freelist_ckpt;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  alloc_count = '0;
   logic [13:0] alloc_preg;
   logic        alloc_ok;
   logic [1:0]  free_valid = '0;
   logic [13:0] free_preg = '0;
   logic [7:0]  ckpt_head_ptr;
   logic        recover_valid = 1'b0;
   logic [7:0]  recover_head_ptr = '0;
   logic [6:0]  free_count;
   logic        overflow_err;
`ifdef FREELIST_DUP_CHECK_EN
   logic        dup_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   phys_freelist_ckpt dut (
      .clk              (clk),
      .reset            (reset),
      .alloc_count      (alloc_count),
      .alloc_preg       (alloc_preg),
      .alloc_ok         (alloc_ok),
      .free_valid       (free_valid),
      .free_preg        (free_preg),
      .ckpt_head_ptr    (ckpt_head_ptr),
      .recover_valid    (recover_valid),
      .recover_head_ptr (recover_head_ptr),
      .free_count       (free_count),
`ifdef FREELIST_DUP_CHECK_EN
      .dup_err          (dup_err),
`endif
      .overflow_err     (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      alloc_count = '0; free_valid = '0; free_preg = '0;
      recover_valid = 1'b0; recover_head_ptr = '0;
      reset = 1'b1;
      step;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      alloc_count = 2'd2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (free_count !== 7'd96) $display("FAIL reset_free_count got=%0d exp=96", free_count); else n_pass++;
      n_checks++;
      if (overflow_err !== 1'b0) $display("FAIL reset_overflow got=%0b exp=0", overflow_err); else n_pass++;
      n_checks++;
      if (alloc_ok !== 1'b1) $display("FAIL reset_alloc_ok got=%0b exp=1", alloc_ok); else n_pass++;
      n_checks++;
      if (ckpt_head_ptr !== 8'd0) $display("FAIL reset_head got=%0d exp=0", ckpt_head_ptr); else n_pass++;
      n_checks++;
      if (alloc_preg !== {7'd33, 7'd32}) $display("FAIL reset_alloc_preg got=%0d,%0d exp=32,33", alloc_preg[6:0], alloc_preg[13:7]); else n_pass++;
      step;
      reset = 1'b0;
   endtask

   task automatic test_drain;
      do_reset;
      alloc_count = 2'd2;
      for (int k = 0; k < 48; k++) begin
         #1;
         n_checks++;
         if (alloc_preg !== {7'(33 + 2*k), 7'(32 + 2*k)} || alloc_ok !== 1'b1)
            $display("FAIL drain_cycle%0d got=%0d,%0d ok=%0b exp=%0d,%0d ok=1", k, alloc_preg[6:0], alloc_preg[13:7], alloc_ok, 32 + 2*k, 33 + 2*k);
         else n_pass++;
         step;
      end
      #1;
      n_checks++;
      if (free_count !== 7'd0) $display("FAIL drain_free_count got=%0d exp=0", free_count); else n_pass++;
      n_checks++;
      if (alloc_ok !== 1'b0) $display("FAIL drain_alloc_ok got=%0b exp=0", alloc_ok); else n_pass++;
      n_checks++;
      if (ckpt_head_ptr !== 8'd96) $display("FAIL drain_head got=%0d exp=96", ckpt_head_ptr); else n_pass++;
      alloc_count = 2'd0;
      #1;
      n_checks++;
      if (alloc_ok !== 1'b1) $display("FAIL empty_alloc0_ok got=%0b exp=1", alloc_ok); else n_pass++;
   endtask

   // Starts from the empty list left by test_drain.
   task automatic test_free_from_empty;
      alloc_count = 2'd0;
      free_valid = 2'b01; free_preg = {7'd0, 7'd40};
      step;
      free_valid = 2'b11; free_preg = {7'd42, 7'd41};
      #1;
      n_checks++;
      if (free_count !== 7'd1) $display("FAIL free_one got=%0d exp=1", free_count); else n_pass++;
      step;
      free_valid = 2'b00;
      alloc_count = 2'd2;
      #1;
      n_checks++;
      if (free_count !== 7'd3) $display("FAIL free_three got=%0d exp=3", free_count); else n_pass++;
      n_checks++;
      if (alloc_preg !== {7'd41, 7'd40} || alloc_ok !== 1'b1) $display("FAIL free_alloc_preg got=%0d,%0d ok=%0b exp=40,41 ok=1", alloc_preg[6:0], alloc_preg[13:7], alloc_ok); else n_pass++;
      step;
      alloc_count = 2'd0;
      free_valid = 2'b10; free_preg = {7'd43, 7'd99};
      #1;
      n_checks++;
      if (free_count !== 7'd1 || alloc_preg[6:0] !== 7'd42) $display("FAIL free_after_alloc got=%0d head_tag=%0d exp=1 head_tag=42", free_count, alloc_preg[6:0]); else n_pass++;
      step;
      free_valid = 2'b11; free_preg = {7'd44, 7'd0};
      step;
      free_valid = 2'b00;
      alloc_count = 2'd2;
      #1;
      n_checks++;
      if (free_count !== 7'd3) $display("FAIL compact_zero_count got=%0d exp=3", free_count); else n_pass++;
      n_checks++;
      if (alloc_preg !== {7'd43, 7'd42}) $display("FAIL compact_order got=%0d,%0d exp=42,43", alloc_preg[6:0], alloc_preg[13:7]); else n_pass++;
      step;
      alloc_count = 2'd2;
      #1;
      n_checks++;
      if (alloc_ok !== 1'b0 || alloc_preg[6:0] !== 7'd44) $display("FAIL one_left got ok=%0b tag=%0d exp ok=0 tag=44", alloc_ok, alloc_preg[6:0]); else n_pass++;
      step;
      n_checks++;
      if (free_count !== 7'd1) $display("FAIL stall_no_change got=%0d exp=1", free_count); else n_pass++;
   endtask

   task automatic test_recover;
      do_reset;
      alloc_count = 2'd2;
      step;
      step;
      n_checks++;
      if (ckpt_head_ptr !== 8'd4) $display("FAIL ckpt_snapshot got=%0d exp=4", ckpt_head_ptr); else n_pass++;
      step;
      step;
      step;
      n_checks++;
      if (free_count !== 7'd86) $display("FAIL pre_recover_count got=%0d exp=86", free_count); else n_pass++;
      recover_valid = 1'b1; recover_head_ptr = 8'd4;
      #1;
      n_checks++;
      if (alloc_ok !== 1'b0) $display("FAIL recover_alloc_ok got=%0b exp=0", alloc_ok); else n_pass++;
      step;
      recover_valid = 1'b0;
      #1;
      n_checks++;
      if (free_count !== 7'd92 || ckpt_head_ptr !== 8'd4) $display("FAIL recover_state got count=%0d head=%0d exp count=92 head=4", free_count, ckpt_head_ptr); else n_pass++;
      n_checks++;
      if (alloc_preg !== {7'd37, 7'd36} || alloc_ok !== 1'b1) $display("FAIL recover_alloc got=%0d,%0d ok=%0b exp=36,37 ok=1", alloc_preg[6:0], alloc_preg[13:7], alloc_ok); else n_pass++;
      step;
      recover_valid = 1'b1; recover_head_ptr = 8'd4;
      free_valid = 2'b11; free_preg = {7'd71, 7'd70};
      #1;
      n_checks++;
      if (alloc_ok !== 1'b0 || free_count !== 7'd90) $display("FAIL recover_free_pre got ok=%0b count=%0d exp ok=0 count=90", alloc_ok, free_count); else n_pass++;
      step;
      recover_valid = 1'b0; free_valid = 2'b00; alloc_count = 2'd0;
      #1;
      n_checks++;
      if (free_count !== 7'd94 || ckpt_head_ptr !== 8'd4) $display("FAIL recover_free_post got count=%0d head=%0d exp count=94 head=4", free_count, ckpt_head_ptr); else n_pass++;
      n_checks++;
      if (alloc_preg !== {7'd37, 7'd36} || overflow_err !== 1'b0) $display("FAIL recover_free_tags got=%0d,%0d ovf=%0b exp=36,37 ovf=0", alloc_preg[6:0], alloc_preg[13:7], overflow_err); else n_pass++;
   endtask

   task automatic test_overflow;
      do_reset;
      free_valid = 2'b01; free_preg = {7'd0, 7'd50};
      step;
      free_valid = 2'b00;
      n_checks++;
      if (overflow_err !== 1'b1 || free_count !== 7'd96) $display("FAIL ovf_full got ovf=%0b count=%0d exp ovf=1 count=96", overflow_err, free_count); else n_pass++;
      alloc_count = 2'd2;
      step;
      alloc_count = 2'd0;
      step;
      n_checks++;
      if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", overflow_err); else n_pass++;
      do_reset;
      n_checks++;
      if (overflow_err !== 1'b0) $display("FAIL ovf_reset_clear got=%0b exp=0", overflow_err); else n_pass++;
      alloc_count = 2'd1;
      step;
      alloc_count = 2'd0;
      free_valid = 2'b11; free_preg = {7'd61, 7'd60};
      step;
      free_valid = 2'b00;
      n_checks++;
      if (overflow_err !== 1'b1 || free_count !== 7'd96) $display("FAIL ovf_partial got ovf=%0b count=%0d exp ovf=1 count=96", overflow_err, free_count); else n_pass++;
   endtask

   task automatic test_back_to_back_wrap;
      int e0;
      int e1;
      do_reset;
      alloc_count = 2'd2;
      free_valid = 2'b11;
      for (int k = 0; k < 200; k++) begin
         e0 = 32 + ((2*k) % 96);
         e1 = 32 + ((2*k + 1) % 96);
         free_preg = {7'(e1), 7'(e0)};
         #1;
         n_checks++;
         if (alloc_preg !== {7'(e1), 7'(e0)} || free_count !== 7'd96 || alloc_ok !== 1'b1)
            $display("FAIL wrap_cycle%0d got=%0d,%0d count=%0d ok=%0b exp=%0d,%0d count=96 ok=1", k, alloc_preg[6:0], alloc_preg[13:7], free_count, alloc_ok, e0, e1);
         else n_pass++;
         step;
      end
      free_valid = 2'b00; alloc_count = 2'd0;
      #1;
      n_checks++;
      if (ckpt_head_ptr !== 8'd16 || free_count !== 7'd96 || overflow_err !== 1'b0) $display("FAIL wrap_final got head=%0d count=%0d ovf=%0b exp head=16 count=96 ovf=0", ckpt_head_ptr, free_count, overflow_err); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_drain;
      test_free_from_empty;
      test_recover;
      test_overflow;
      test_back_to_back_wrap;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
